seq_rec_trig_core: RTL and testbench

//  Single-clock sequence recorder core with pre-trigger ring buffer. Samples SEQ_IN every BUS_CLK into

---
 rtl/seq_rec_trig_core.sv | 190 +++++++++++++++++++
 tb/tb_seq_rec_trig_core.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_rec_trig_core.sv
// Sequence recorder: samples seq_in every cycle into a ring buffer, trigger on ext edge or masked pattern.
// Register/memory reads return 1 cycle after bus_rd; no backpressure. Pattern trigger: SEQ_REC_PATTERN_TRIG_EN.
module seq_rec_trig_core #(
  parameter int ABUSWIDTH = 16,
  parameter int MEM_BYTES = 8192,
  parameter int IN_BITS   = 8,
  parameter int VERSION   = 1
) (
  input  logic                 bus_clk,
  input  logic                 bus_rst,
  input  logic [ABUSWIDTH-1:0] bus_add,
  input  logic [7:0]           bus_data_in,
  input  logic                 bus_rd,
  input  logic                 bus_wr,
  output logic [7:0]           bus_data_out,
  input  logic [IN_BITS-1:0]   seq_in,
  input  logic                 seq_ext_start
);
  localparam int NB    = IN_BITS / 8;
  localparam int DEPTH = MEM_BYTES / NB;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = (AW + 1 > 17) ? AW + 1 : 17;
  localparam logic [31:0] MEM_SPAN = 32'(DEPTH * NB);
  localparam logic [31:0] NB32     = 32'(NB);

  typedef enum logic [1:0] {S_IDLE, S_PREFILL, S_WAIT, S_POST} state_t;
  state_t state_q, state_d;

  logic [15:0]        size_q, pre_q;
  logic [2:0]         conf_q;
  logic [AW-1:0]      ptr_q, trig_addr_q;
  logic [CW-1:0]      cnt_q, eff_pre_q, post_q;
  logic [CW-1:0]      eff_size, eff_pre;
  logic               done_q, trigd_q, ext_q;
  logic               rec, trig_fire, fin, armed;
  logic               soft_rst, wr_start, is_reg, ext_edge, pat_hit;
  logic [31:0]        add32, mem_off, mem_k, mem_b;
  logic [IN_BITS-1:0] mem [DEPTH];
  logic [IN_BITS-1:0] mem_word;
  logic [7:0]         rd_dat, pat_rd;
  logic [2:0]         conf_mask;

  assign add32    = 32'(bus_add);
  assign is_reg   = add32 < 32'd32;
  assign soft_rst = bus_wr && (add32 == 32'd0);
  assign wr_start = bus_wr && (add32 == 32'd1);
  assign armed    = (state_q != S_IDLE);

  // Zero or oversized SIZE means the whole ring; pre-trigger must leave room for the trigger sample.
  assign eff_size = ((size_q == 16'd0) || (CW'(size_q) > CW'(DEPTH))) ? CW'(DEPTH) : CW'(size_q);
  assign eff_pre  = (CW'(pre_q) >= eff_size) ? eff_size - CW'(1) : CW'(pre_q);

  assign ext_edge = conf_q[2] ? (ext_q & ~seq_ext_start) : (~ext_q & seq_ext_start);

`ifdef SEQ_REC_PATTERN_TRIG_EN
  logic [31:0] pattern_q, mask_q;
  assign conf_mask = 3'b111;
  assign pat_hit   = conf_q[1] && (((seq_in ^ pattern_q[IN_BITS-1:0]) & mask_q[IN_BITS-1:0]) == '0);
  assign pat_rd    = bus_add[2] ? mask_q[{bus_add[1:0], 3'b000} +: 8]
                                : pattern_q[{bus_add[1:0], 3'b000} +: 8];
  always_ff @(posedge bus_clk) begin
    if (bus_rst || soft_rst) begin
      pattern_q <= '0;
      mask_q    <= '0;
    end else if (bus_wr && is_reg && (bus_add[4:3] == 2'b01)) begin
      if (bus_add[2]) mask_q[{bus_add[1:0], 3'b000} +: 8]    <= bus_data_in;
      else            pattern_q[{bus_add[1:0], 3'b000} +: 8] <= bus_data_in;
    end
  end
`else
  assign conf_mask = 3'b101;
  assign pat_hit   = 1'b0;
  assign pat_rd    = 8'h00;
`endif

  always_comb begin
    state_d   = state_q;
    rec       = 1'b0;
    trig_fire = 1'b0;
    fin       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (wr_start) state_d = (eff_pre == '0) ? S_WAIT : S_PREFILL;
      end
      S_PREFILL: begin
        rec = 1'b1;
        if (cnt_q == eff_pre_q - CW'(1)) state_d = S_WAIT;
      end
      S_WAIT: begin
        rec = 1'b1;
        if ((conf_q[0] && ext_edge) || pat_hit) begin
          trig_fire = 1'b1;
          if (post_q == CW'(1)) begin
            state_d = S_IDLE;
            fin     = 1'b1;
          end else begin
            state_d = S_POST;
          end
        end
      end
      S_POST: begin
        rec = 1'b1;
        if (cnt_q == post_q - CW'(1)) begin
          state_d = S_IDLE;
          fin     = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge bus_clk) begin
    if (bus_rst || soft_rst) begin
      state_q      <= S_IDLE;
      size_q       <= '0;
      pre_q        <= '0;
      conf_q       <= '0;
      ptr_q        <= '0;
      trig_addr_q  <= '0;
      cnt_q        <= '0;
      eff_pre_q    <= '0;
      post_q       <= '0;
      done_q       <= 1'b0;
      trigd_q      <= 1'b0;
      bus_data_out <= 8'h00;
    end else begin
      state_q <= state_d;
      if (bus_rd) bus_data_out <= rd_dat;
      if (bus_wr && is_reg) begin
        case (bus_add[4:0])
          5'd2:    size_q[7:0]  <= bus_data_in;
          5'd3:    size_q[15:8] <= bus_data_in;
          5'd4:    pre_q[7:0]   <= bus_data_in;
          5'd5:    pre_q[15:8]  <= bus_data_in;
          5'd6:    conf_q       <= bus_data_in[2:0] & conf_mask;
          default: ;
        endcase
      end
      if (state_q == S_IDLE && wr_start) begin
        ptr_q     <= '0;
        cnt_q     <= '0;
        done_q    <= 1'b0;
        trigd_q   <= 1'b0;
        eff_pre_q <= eff_pre;
        post_q    <= eff_size - eff_pre;
      end
      if (rec) ptr_q <= ptr_q + AW'(1);
      if (state_q == S_PREFILL || state_q == S_POST) cnt_q <= cnt_q + CW'(1);
      // The trigger sample is the first of the post-trigger samples.
      if (trig_fire) begin
        trig_addr_q <= ptr_q;
        trigd_q     <= 1'b1;
        cnt_q       <= CW'(1);
      end
      if (fin) done_q <= 1'b1;
    end
  end

  // Sample RAM and edge history are not reset so soft reset keeps recorded data.
  always_ff @(posedge bus_clk) begin
    ext_q <= seq_ext_start;
    if (rec) mem[ptr_q] <= seq_in;
  end

  assign mem_off  = add32 - 32'd32;
  assign mem_k    = mem_off / NB32;
  assign mem_b    = mem_off % NB32;
  assign mem_word = mem[AW'(mem_k)];

  always_comb begin
    rd_dat = 8'h00;
    if (!is_reg) begin
      if (mem_off < MEM_SPAN) rd_dat = 8'(mem_word >> (mem_b * 32'd8));
    end else begin
      case (bus_add[4:0])
        5'd0:  rd_dat = 8'(VERSION);
        5'd1:  rd_dat = {5'b0, trigd_q, armed, done_q};
        5'd2:  rd_dat = size_q[7:0];
        5'd3:  rd_dat = size_q[15:8];
        5'd4:  rd_dat = pre_q[7:0];
        5'd5:  rd_dat = pre_q[15:8];
        5'd6:  rd_dat = {5'b0, conf_q};
        5'd8, 5'd9, 5'd10, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15: rd_dat = pat_rd;
        5'd16: rd_dat = 8'(trig_addr_q);
        5'd17: rd_dat = 8'(16'(trig_addr_q) >> 8);
        default: rd_dat = 8'h00;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_rec_trig_core.sv
// Directed bench: two recorder instances (8-bit deep ring, 16-bit small ring) driven over a shared bus.
module tb_seq_rec_trig_core;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] add;
  logic [7:0]  din;
  logic        rd8, wr8, rd16, wr16;
  logic [7:0]  dout8, dout16;
  logic [7:0]  seq8;
  logic [15:0] seq16;
  logic        ext8, ext16;
  logic        seq_run;
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  seq_rec_trig_core #(.ABUSWIDTH(16), .MEM_BYTES(8192), .IN_BITS(8), .VERSION(1)) u8 (
    .bus_clk(clk), .bus_rst(rst), .bus_add(add), .bus_data_in(din), .bus_rd(rd8), .bus_wr(wr8),
    .bus_data_out(dout8), .seq_in(seq8), .seq_ext_start(ext8));

  seq_rec_trig_core #(.ABUSWIDTH(16), .MEM_BYTES(64), .IN_BITS(16), .VERSION(2)) u16 (
    .bus_clk(clk), .bus_rst(rst), .bus_add(add), .bus_data_in(din), .bus_rd(rd16), .bus_wr(wr16),
    .bus_data_out(dout16), .seq_in(seq16), .seq_ext_start(ext16));

  // Free-running sample counter, updated just after each rising edge.
  initial forever begin
    @(posedge clk);
    #2;
    if (seq_run) seq8 = seq8 + 8'd1;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic bwr(input bit u, input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    add = a; din = d;
    if (u) wr16 = 1'b1; else wr8 = 1'b1;
    @(negedge clk);
    wr8 = 1'b0; wr16 = 1'b0;
  endtask

  task automatic brd(input bit u, input logic [15:0] a, output logic [7:0] d);
    @(negedge clk);
    add = a;
    if (u) rd16 = 1'b1; else rd8 = 1'b1;
    @(negedge clk);
    rd8 = 1'b0; rd16 = 1'b0;
    d = u ? dout16 : dout8;
  endtask

  task automatic rchk(input bit u, input logic [15:0] a, input logic [7:0] exp, input string tag);
    logic [7:0] d;
    brd(u, a, d);
    check(tag, {8'h00, d}, {8'h00, exp});
  endtask

  // START on the 8-bit instance; the counter reaches 0 exactly for the first recorded sample.
  task automatic start8();
    @(negedge clk);
    add = 16'd1; din = 8'h00; wr8 = 1'b1; seq8 = 8'hFF; seq_run = 1'b1;
    @(negedge clk);
    wr8 = 1'b0;
  endtask

  task automatic wait_seq(input logic [7:0] v);
    for (int i = 0; i < 2000 && seq8 !== v; i++) @(negedge clk);
  endtask

  task automatic pulse8();
    ext8 = 1'b1;
    @(negedge clk);
    ext8 = 1'b0;
  endtask

  task automatic wait_done(input bit u, input int budget, input string tag);
    logic [7:0] d;
    d = 8'h00;
    for (int i = 0; i < budget && d[0] !== 1'b1; i++) brd(u, 16'd1, d);
    check(tag, {8'h00, d}, 16'h0005);
  endtask

  logic [15:0] tbl [10];

  initial begin
    rst = 1'b1; add = '0; din = '0; rd8 = 0; wr8 = 0; rd16 = 0; wr16 = 0;
    seq8 = '0; seq16 = '0; ext8 = 0; ext16 = 0; seq_run = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("dout_after_reset", {8'h00, dout8}, 16'h0000);
    rchk(0, 16'd1, 8'h00, "status_reset8");
    rchk(0, 16'd0, 8'h01, "version8");
    rchk(0, 16'd2, 8'h00, "size_reset");
    rchk(0, 16'd4, 8'h00, "pre_reset");
    rchk(0, 16'd17, 8'h00, "trig_hi_reset");
    rchk(1, 16'd1, 8'h00, "status_reset16");
    rchk(1, 16'd0, 8'h02, "version16");

    // External rising-edge trigger, SIZE=16 PRE=4
    bwr(0, 16'd2, 8'd16); bwr(0, 16'd3, 8'd0); bwr(0, 16'd4, 8'd4); bwr(0, 16'd5, 8'd0);
    bwr(0, 16'd6, 8'h01); bwr(0, 16'd7, 8'h5A);
    rchk(0, 16'd2, 8'd16, "size_readback");
    rchk(0, 16'd6, 8'h01, "conf_readback");
    rchk(0, 16'd7, 8'h00, "unmapped_reg");
    start8();
    rchk(0, 16'd1, 8'h02, "armed_t2");
    wait_seq(8'h40);
    pulse8();
    wait_done(0, 50, "done_t2");
    rchk(0, 16'd16, 8'h40, "trig_lo_t2");
    rchk(0, 16'd17, 8'h00, "trig_hi_t2");
    for (int k = 0; k < 16; k++)
      rchk(0, 16'(32 + 8'h3C + k), 8'(8'h3C + k), "window_t2");

    // PRE clamped to SIZE-1, falling-edge trigger: DONE right after the trigger sample
    bwr(0, 16'd2, 8'd8); bwr(0, 16'd4, 8'd20); bwr(0, 16'd6, 8'h05);
    ext8 = 1'b1;
    start8();
    rchk(0, 16'd1, 8'h02, "armed_t3");
    wait_seq(8'h20);
    ext8 = 1'b0;
    rchk(0, 16'd1, 8'h05, "done_after_trig_t3");
    rchk(0, 16'd16, 8'h20, "trig_lo_t3");
    rchk(0, 16'(32 + 8'h19), 8'h19, "first_pre_t3");

    // Soft reset during POST, then trigger in PREFILL ignored
    bwr(0, 16'd2, 8'd0); bwr(0, 16'd4, 8'd4); bwr(0, 16'd6, 8'h01);
    start8();
    wait_seq(8'h10);
    pulse8();
    rchk(0, 16'd1, 8'h06, "in_post_t6");
    bwr(0, 16'd0, 8'h00);
    rchk(0, 16'd1, 8'h00, "soft_rst_status");
    rchk(0, 16'd2, 8'h00, "soft_rst_size");
    rchk(0, 16'd6, 8'h00, "soft_rst_conf");
    bwr(0, 16'd2, 8'd16); bwr(0, 16'd4, 8'd8); bwr(0, 16'd6, 8'h01);
    start8();
    wait_seq(8'h03);
    pulse8();
    wait_seq(8'h30);
    pulse8();
    wait_done(0, 50, "done_t6");
    rchk(0, 16'd16, 8'h30, "trig_lo_t6");
    rchk(0, 16'(32 + 8'h28), 8'h28, "window_t6");

    // Ring wrap: full depth, PRE=100, trigger at sample 10000
    bwr(0, 16'd2, 8'd0); bwr(0, 16'd4, 8'd100); bwr(0, 16'd6, 8'h01);
    start8();
    repeat (10000) @(negedge clk);
    pulse8();
    wait_done(0, 9000, "done_t4");
    rchk(0, 16'd16, 8'h10, "trig_lo_t4");
    rchk(0, 16'd17, 8'h07, "trig_hi_t4");
    rchk(0, 16'd1740, 8'hAC, "pre_first_t4");
    rchk(0, 16'd1839, 8'h0F, "pre_last_t4");
    rchk(0, 16'd1739, 8'hAB, "post_last_t4");
    bwr(0, 16'd1740, 8'h55);
    rchk(0, 16'd1740, 8'hAC, "mem_write_ignored");
    rchk(0, 16'd8224, 8'h00, "mem_out_of_range");

    // Pattern trigger on the 16-bit instance
    bwr(1, 16'd2, 8'd8); bwr(1, 16'd4, 8'd2); bwr(1, 16'd6, 8'h02);
    bwr(1, 16'd8, 8'hA5); bwr(1, 16'd9, 8'hA5); bwr(1, 16'd12, 8'h00); bwr(1, 16'd13, 8'hFF);
    tbl = '{16'hA5FF, 16'hA5AA, 16'h1234, 16'h5A12, 16'hA512,
            16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005};
`ifdef SEQ_REC_PATTERN_TRIG_EN
    rchk(1, 16'd8, 8'hA5, "pattern_readback");
    rchk(1, 16'd6, 8'h02, "conf_pat_readback");
`else
    rchk(1, 16'd8, 8'h00, "pattern_absent");
    rchk(1, 16'd6, 8'h00, "conf_pat_absent");
`endif
    bwr(1, 16'd1, 8'h00);
    for (int i = 0; i < 10; i++) begin
      seq16 = tbl[i];
      @(negedge clk);
    end
    seq16 = 16'h0000;
`ifdef SEQ_REC_PATTERN_TRIG_EN
    rchk(1, 16'd1, 8'h05, "done_t5");
    rchk(1, 16'd16, 8'h04, "trig_lo_t5");
    rchk(1, 16'd40, 8'h12, "trig_sample_lo");
    rchk(1, 16'd41, 8'hA5, "trig_sample_hi");
    rchk(1, 16'd36, 8'h34, "sample2_lo");
    rchk(1, 16'd37, 8'h12, "sample2_hi");
`else
    rchk(1, 16'd1, 8'h02, "no_pattern_trigger");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
